// File: rtl/bp_pkg.sv
// Shared types and constants for the bimodal branch direction predictor.
package bp_pkg;

    localparam int unsigned PRED_INDEX_BITS = 10;

    typedef logic [1:0] ctr_t;

    localparam ctr_t CTR_SNT = 2'b00;
    localparam ctr_t CTR_WNT = 2'b01;
    localparam ctr_t CTR_WT  = 2'b10;
    localparam ctr_t CTR_ST  = 2'b11;

endpackage

// File: rtl/branch_pred_counters_if.sv
// ID-stage training inputs and the flat per-entry prediction vector.
interface branch_pred_counters_if #(
    parameter int unsigned INDEX_BITS = bp_pkg::PRED_INDEX_BITS
);
    logic                       isTaken;
    logic                       isBranch;
    logic [31:0]                InstrPC;
    logic [2**INDEX_BITS-1:0]   Pred;

    modport master (output isTaken, output isBranch, output InstrPC, input Pred);
    modport slave  (input isTaken, input isBranch, input InstrPC, output Pred);
endinterface

// File: rtl/sat_counter_2b.sv
// One 2-bit saturating direction counter; pred is the counter MSB.
module sat_counter_2b
    import bp_pkg::*;
#(
    parameter ctr_t RESET_STATE = CTR_WNT
) (
    input  logic CLK,
    input  logic RESET,
    input  logic en,
    input  logic taken,
    output ctr_t state,
    output logic pred
);

    ctr_t state_q, state_d;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            CTR_SNT: state_d = taken ? CTR_WNT : CTR_SNT;
            CTR_WNT: state_d = taken ? CTR_WT  : CTR_SNT;
            CTR_WT:  state_d = taken ? CTR_ST  : CTR_WNT;
            CTR_ST:  state_d = taken ? CTR_ST  : CTR_WT;
            default: state_d = state_q;
        endcase
    end

    // Reset wins over a simultaneous training request.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_q <= RESET_STATE;
        end else if (en) begin
            state_q <= state_d;
        end
    end

    assign state = state_q;
    assign pred  = state_q[1];

endmodule

// File: rtl/branch_pred_counters.sv
// Bimodal predictor: index decoder feeding 2**INDEX_BITS saturating counters.
module branch_pred_counters
    import bp_pkg::*;
#(
    parameter int unsigned INDEX_BITS  = PRED_INDEX_BITS,
    parameter ctr_t        RESET_STATE = CTR_WNT
) (
    input  logic                   CLK,
    input  logic                   RESET,
    branch_pred_counters_if.slave  bus
);

    localparam int unsigned DEPTH = 2**INDEX_BITS;

    logic [INDEX_BITS-1:0]   idx;
    logic [DEPTH-1:0]        en_vec;
    logic [DEPTH-1:0]        pred_vec;
    logic [DEPTH-1:0][1:0]   ctr_state;

    // PC bits outside the index field alias deliberately.
    assign idx = bus.InstrPC[INDEX_BITS+1:2];

    logic unused_pc;
    assign unused_pc = ^{bus.InstrPC[31:INDEX_BITS+2], bus.InstrPC[1:0]};

    always_comb begin
        en_vec = '0;
        if (bus.isBranch) begin
            en_vec[idx] = 1'b1;
        end
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_ctr
        sat_counter_2b #(
            .RESET_STATE (RESET_STATE)
        ) u_ctr (
            .CLK   (CLK),
            .RESET (RESET),
            .en    (en_vec[i]),
            .taken (bus.isTaken),
            .state (ctr_state[i]),
            .pred  (pred_vec[i])
        );
    end

    // Full counter state is kept for debug visibility only.
    logic unused_ctr_state;
    assign unused_ctr_state = ^ctr_state;

    assign bus.Pred = pred_vec;

endmodule

// File: tb/tb_branch_pred_counters.sv
// Self-checking bench: directed vector table plus randomized training vs an array model.
module tb_branch_pred_counters;

    localparam int DEPTH = 1024;

    logic CLK = 1'b0;
    logic RESET;

    branch_pred_counters_if bus ();

    branch_pred_counters dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    int model [DEPTH];
    int n_vec = 0;
    int n_fail = 0;

    typedef struct {
        string       name;
        bit          rst_n;
        bit          br;
        bit          tk;
        logic [31:0] pc;
        int          idx;
        bit          exp;
    } vec_t;

    task automatic step(input bit rst_n, input bit br, input bit tk, input logic [31:0] pc);
        int ix;
        @(negedge CLK);
        RESET        = rst_n;
        bus.isBranch = br;
        bus.isTaken  = tk;
        bus.InstrPC  = pc;
        @(posedge CLK);
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) model[i] = 1;
        end else if (br) begin
            ix = int'((pc >> 2) % DEPTH);
            if (tk) model[ix] = (model[ix] + 1 > 3) ? 3 : model[ix] + 1;
            else    model[ix] = (model[ix] - 1 < 0) ? 0 : model[ix] - 1;
        end
        #1;
    endtask

    task automatic check_all(input string name);
        logic [DEPTH-1:0] exp;
        int first;
        for (int i = 0; i < DEPTH; i++) exp[i] = (model[i] >= 2);
        n_vec++;
        if (bus.Pred !== exp) begin
            first = -1;
            for (int i = DEPTH - 1; i >= 0; i--) if (bus.Pred[i] !== exp[i]) first = i;
            n_fail++;
            $display("FAIL %s: Pred[%0d] got %b expected %b", name, first, bus.Pred[first],
                     exp[first]);
        end
    endtask

    task automatic check_bit(input string name, input int idx, input bit exp);
        n_vec++;
        if (bus.Pred[idx] !== exp) begin
            n_fail++;
            $display("FAIL %s: Pred[%0d] got %b expected %b", name, idx, bus.Pred[idx], exp);
        end
    endtask

    task automatic check_zero_and_peek(input string name);
        int bad;
        n_vec++;
        if (bus.Pred !== '0) begin
            n_fail++;
            $display("FAIL %s: Pred not all zero, popcount %0d", name, $countones(bus.Pred));
        end
        bad = 0;
        for (int i = 0; i < DEPTH; i++) if (dut.ctr_state[i] !== 2'b01) bad++;
        n_vec++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL %s_peek: %0d counters not 01, expected 0", name, bad);
        end
    endtask

    vec_t vecs [$];

    initial begin
        logic [31:0] pc;
        RESET        = 1'b0;
        bus.isBranch = 1'b0;
        bus.isTaken  = 1'b0;
        bus.InstrPC  = '0;

        vecs.push_back('{"sat_up1",   1, 1, 1, 32'h0000_0010,    4, 1});
        vecs.push_back('{"sat_up2",   1, 1, 1, 32'h0000_0010,    4, 1});
        vecs.push_back('{"sat_up3",   1, 1, 1, 32'h0000_0010,    4, 1});
        vecs.push_back('{"sat_up4",   1, 1, 1, 32'h0000_0010,    4, 1});
        vecs.push_back('{"down1",     1, 1, 0, 32'h0000_0010,    4, 1});
        vecs.push_back('{"down2",     1, 1, 0, 32'h0000_0010,    4, 0});
        vecs.push_back('{"down3",     1, 1, 0, 32'h0000_0010,    4, 0});
        vecs.push_back('{"down4",     1, 1, 0, 32'h0000_0010,    4, 0});
        vecs.push_back('{"down5",     1, 1, 0, 32'h0000_0010,    4, 0});
        vecs.push_back('{"up_from0",  1, 1, 1, 32'h0000_0010,    4, 0});
        for (int i = 0; i < 5; i++)
            vecs.push_back('{"gated",  1, 0, 1, 32'h0000_0FFC, 1023, 0});
        vecs.push_back('{"ungated",   1, 1, 1, 32'h0000_0FFC, 1023, 1});
        vecs.push_back('{"alias_a",   1, 1, 1, 32'h0000_1008,    2, 1});
        vecs.push_back('{"alias_b",   1, 1, 1, 32'hFFFF_F00B,    2, 1});
        vecs.push_back('{"rst_mid",   0, 1, 1, 32'h0000_1008,    2, 0});

        // Reset held for two edges, then released idle.
        step(0, 0, 0, 32'h0);
        step(0, 0, 0, 32'h0);
        step(1, 0, 0, 32'h0);
        check_zero_and_peek("reset");

        foreach (vecs[k]) begin
            step(vecs[k].rst_n, vecs[k].br, vecs[k].tk, vecs[k].pc);
            check_bit(vecs[k].name, vecs[k].idx, vecs[k].exp);
            check_all({vecs[k].name, "_all"});
        end
        check_zero_and_peek("rst_mid_state");

        // Random training, biased to a few hot indices so counters saturate.
        for (int n = 0; n < 3000; n++) begin
            pc = $urandom;
            if ($urandom_range(0, 3) != 0) pc[11:2] = 10'($urandom_range(0, 7));
            step(($urandom_range(0, 199) != 0), ($urandom_range(0, 2) != 0),
                 ($urandom_range(0, 1) == 1), pc);
            check_all("random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
